// File: rtl/calc_sequencer.sv
// calc_sequencer: arbitrates two requesters onto a shared calculator datapath and keeps a two-deep result history.
// Define CALC_SEQ_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module calc_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] a0,
    input  logic [2:0] a1,
    input  logic [2:0] b0,
    input  logic [2:0] b1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] dp_a,
    output logic [2:0] dp_b,
    output logic [1:0] dp_op,
    output logic       dp_load,
    input  logic [5:0] dp_result,
    output logic [5:0] cur_val,
    output logic [5:0] prev_val,
    output logic       busy,
    output logic       grant_id
);
`ifdef CALC_SEQ_RR_EN
    localparam logic GRANT_RST = 1'b1;
`else
    localparam logic GRANT_RST = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       win;
`ifdef CALC_SEQ_RR_EN
    assign win = (req0 && req1) ? ~grant_id : req1;
`else
    assign win = ~req0;
`endif
    // dp_a/dp_b/dp_op double as the latched operands: loaded at grant, cleared on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_op    <= '0;
            dp_load  <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            cur_val  <= '0;
            prev_val <= '0;
            grant_id <= GRANT_RST;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state    <= ISSUE;
                    busy     <= 1'b1;
                    dp_load  <= 1'b1;
                    grant_id <= win;
                    dp_a     <= win ? a1 : a0;
                    dp_b     <= win ? b1 : b0;
                    dp_op    <= win ? op1 : op0;
                end
                ISSUE, WAIT: begin
                    dp_load <= 1'b0;
                    cnt     <= (state == ISSUE) ? 4'(WAIT_CYCLES) : cnt - 4'd1;
                    if (state == ISSUE ? WAIT_CYCLES == 0 : cnt == 4'd1) begin
                        state <= COMMIT;
                        ack0  <= ~grant_id;
                        ack1  <= grant_id;
                    end else begin
                        state <= WAIT;
                    end
                end
                COMMIT: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    prev_val <= cur_val;
                    cur_val  <= dp_result;
                    dp_a     <= '0;
                    dp_b     <= '0;
                    dp_op    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed table, multi-cycle corner cases and a randomized run against a transaction-level model.
// Honours CALC_SEQ_RR_EN the same way as the design.
module tb_calc_sequencer;
    localparam int W = 2;
`ifdef CALC_SEQ_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    typedef struct packed {
        logic       r;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
        logic [5:0] res;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [1:0] op0 = '0, op1 = '0;
    logic       ack0, ack1, dp_load, busy, grant_id;
    logic [2:0] dp_a, dp_b;
    logic [1:0] dp_op;
    logic [5:0] dp_result, cur_val, prev_val;
    logic       z_req = 1'b0;
    logic [2:0] z_a = '0, z_b = '0;
    logic [1:0] z_op = '0;
    logic       z_ack0, z_ack1, z_load, z_busy, z_gid;
    logic [2:0] z_dpa, z_dpb;
    logic [1:0] z_dpop;
    logic [5:0] z_res, z_cur, z_prev;
    int         total = 0, bad = 0, sl = 100, zsl = 100;
    vec_t       tbl [6];
    logic       mbusy, mw, mgid;
    logic [2:0] la, lb;
    logic [1:0] lop;
    logic [5:0] mcur, mprev;
    int         cyc, gcyc, done_at, zkl, zka, nack;
    logic       p [2];
    logic       ea [2];

    function automatic logic [5:0] f(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return 6'(a) + 6'(b);
            2'd1:    return 6'(a) * 6'(b);
            2'd2:    return 6'(a ^ b);
            default: return {a, b};
        endcase
    endfunction

    calc_sequencer #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .op0(op0), .op1(op1), .ack0(ack0), .ack1(ack1), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_load(dp_load), .dp_result(dp_result), .cur_val(cur_val), .prev_val(prev_val),
        .busy(busy), .grant_id(grant_id)
    );

    calc_sequencer #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .req0(z_req), .req1(1'b0), .a0(z_a), .a1(3'd0), .b0(z_b), .b1(3'd0),
        .op0(z_op), .op1(2'd0), .ack0(z_ack0), .ack1(z_ack1), .dp_a(z_dpa), .dp_b(z_dpb), .dp_op(z_dpop),
        .dp_load(z_load), .dp_result(z_res), .cur_val(z_cur), .prev_val(z_prev),
        .busy(z_busy), .grant_id(z_gid)
    );

    always #5 clk = ~clk;

    // datapath stand-in: result is correct only in the cycle it is due, inverted otherwise
    always @(posedge clk) begin
        sl  <= dp_load ? 1 : sl + 1;
        zsl <= z_load ? 1 : zsl + 1;
    end
    assign dp_result = (sl == W + 1) ? f(dp_a, dp_b, dp_op) : ~f(dp_a, dp_b, dp_op);
    assign z_res     = (zsl == 1) ? f(z_dpa, z_dpb, z_dpop) : ~f(z_dpa, z_dpb, z_dpop);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn(input int idx, input vec_t v, input logic [5:0] ep);
        int kl = -1, ka = -1, oth = 0, drift = 0;
        if (v.r) {req1, a1, b1, op1} = {1'b1, v.a, v.b, v.op};
        else     {req0, a0, b0, op0} = {1'b1, v.a, v.b, v.op};
        for (int k = 1; k <= 20 && ka < 0; k++) begin
            tick();
            if (k == 1) begin
                if (v.r) {a1, b1, op1} = ~{v.a, v.b, v.op};
                else     {a0, b0, op0} = ~{v.a, v.b, v.op};
            end
            if (dp_load && kl < 0) kl = k;
            if (v.r ? ack0 : ack1) oth++;
            if (k <= W + 2 && {dp_a, dp_b, dp_op} != {v.a, v.b, v.op}) drift++;
            if (v.r ? ack1 : ack0) ka = k;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk($sformatf("load_at[%0d]", idx), kl, 1);
        chk($sformatf("ack_at[%0d]", idx), ka, W + 2);
        chk($sformatf("other_ack[%0d]", idx), oth, 0);
        chk($sformatf("dp_drift[%0d]", idx), drift, 0);
        chk($sformatf("cur_val[%0d]", idx), cur_val, v.res);
        chk($sformatf("prev_val[%0d]", idx), prev_val, ep);
        chk($sformatf("grant_busy[%0d]", idx), {grant_id, busy}, {v.r, 1'b0});
    endtask

    initial begin
        tbl[0] = '{1'b0, 3'd5, 3'd3, 2'd0, 6'd8};
        tbl[1] = '{1'b0, 3'd1, 3'd3, 2'd0, 6'd4};
        tbl[2] = '{1'b1, 3'd7, 3'd7, 2'd1, 6'd49};
        tbl[3] = '{1'b1, 3'd6, 3'd3, 2'd2, 6'd5};
        tbl[4] = '{1'b1, 3'd0, 3'd0, 2'd0, 6'd0};
        tbl[5] = '{1'b0, 3'd7, 3'd2, 2'd3, 6'd58};
        tick();
        tick();
        chk("reset_state", {busy, dp_load, ack0, ack1, grant_id, dp_a, dp_b, dp_op, cur_val, prev_val},
            {4'b0, RR, 20'b0});
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) txn(i, tbl[i], i == 0 ? 6'd0 : tbl[i-1].res);

        // abort in WAIT: asynchronous clear, no ack afterwards
        {req0, a0, b0, op0} = {1'b1, 3'd3, 3'd3, 2'd0};
        tick();
        tick();
        chk("abort_pre", {busy, dp_load}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("abort_clear", {busy, dp_load, ack0, ack1, dp_a, dp_b, dp_op, cur_val, prev_val}, 0);
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        nack = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ack0 || ack1 || busy) nack++;
        end
        chk("abort_no_ack", nack, 0);

        // contention straight after reset
        {req0, a0, b0, op0, req1, a1, b1, op1} = {1'b1, 3'd1, 3'd1, 2'd0, 1'b1, 3'd2, 3'd2, 2'd0};
        for (int n = 0; n < 4; n++) begin
            int got = -1;
            for (int k = 0; k < 20 && got < 0; k++) begin
                tick();
                got = (ack0 && ack1) ? 2 : ack0 ? 0 : ack1 ? 1 : -1;
            end
            chk($sformatf("contend[%0d]", n), got, RR ? n % 2 : 0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // zero-wait instance
        for (int n = 0; n < 2; n++) begin
            z_req = 1'b1;
            {z_a, z_b, z_op} = (n == 0) ? {3'd5, 3'd3, 2'd0} : {3'd2, 3'd2, 2'd1};
            zkl = -1;
            zka = -1;
            for (int k = 1; k <= 10 && zka < 0; k++) begin
                tick();
                if (z_load && zkl < 0) zkl = k;
                if (z_ack0) zka = k;
            end
            z_req = 1'b0;
            tick();
            chk($sformatf("z_load_at[%0d]", n), zkl, 1);
            chk($sformatf("z_ack_at[%0d]", n), zka, 2);
            chk($sformatf("z_cur[%0d]", n), z_cur, n == 0 ? 8 : 4);
            chk($sformatf("z_prev[%0d]", n), z_prev, n == 0 ? 0 : 8);
        end
        chk("z_idle", {z_gid, z_ack1, z_busy}, 0);

        // randomized run against a transaction-level model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        {mbusy, mw, mgid, mcur, mprev} = {2'b00, RR, 12'd0};
        {la, lb, lop} = '0;
        cyc = 0;
        gcyc = -10;
        done_at = -10;
        p[0] = 1'b0;
        p[1] = 1'b0;
        for (int i = 0; i < 4000 && bad < 20; i++) begin
            ea[0] = mbusy && cyc == done_at && !mw;
            ea[1] = mbusy && cyc == done_at && mw;
            rst_n = ($urandom % 300) != 0;
            for (int r = 0; r < 2; r++) begin
                if (!rst_n || ea[r]) p[r] = 1'b0;
                else if (!p[r]) p[r] = ($urandom % 3) == 0;
                else if (!(mbusy && mw == 1'(r)) && ($urandom % 8) == 0) p[r] = 1'b0;
            end
            req0 = p[0];
            req1 = p[1];
            {a0, b0, op0, a1, b1, op1} = 16'($urandom);
            @(posedge clk);
            if (!rst_n) begin
                {mbusy, mgid, mcur, mprev} = {1'b0, RR, 12'd0};
            end else if (mbusy && cyc == done_at) begin
                mprev = mcur;
                mcur = f(la, lb, lop);
                mbusy = 1'b0;
            end else if (!mbusy && (req0 || req1)) begin
                mw = (req0 && req1) ? (RR ? !mgid : 1'b0) : req1;
                mgid = mw;
                {la, lb, lop} = mw ? {a1, b1, op1} : {a0, b0, op0};
                mbusy = 1'b1;
                gcyc = cyc;
                done_at = cyc + 2 + W;
            end
            cyc++;
            @(negedge clk);
            chk($sformatf("rand@%0d", i),
                {busy, dp_load, ack0, ack1, grant_id, dp_a, dp_b, dp_op, cur_val, prev_val},
                {mbusy, mbusy && cyc == gcyc + 1, mbusy && cyc == done_at && !mw, mbusy && cyc == done_at && mw,
                 mgid, mbusy ? la : 3'd0, mbusy ? lb : 3'd0, mbusy ? lop : 2'd0, mcur, mprev});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
